// File: rtl/iob_fifo_wr_arbiter_pkg.sv
// Shared types for the FIFO write-port arbiter: the two-state grant FSM encoding.
package iob_fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/iob_rr_prio_enc.sv
// Combinational round-robin priority encoder: searches upward from last_id+1,
// wrapping at N, and reports the first requester found.
module iob_rr_prio_enc #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_id,
    output logic [ID_W-1:0] winner_id,
    output logic            any
);

    // Wraps at N rather than 2**ID_W so non-power-of-two N works.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(N - 1)) ? '0 : id + 1'b1;
    endfunction

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        logic [ID_W-1:0] idx;
        winner_id = '0;
        any       = 1'b0;
        idx       = next_id(last_id);
        for (int i = 0; i < N; i++) begin
            if (!any && req[idx]) begin
                any       = 1'b1;
                winner_id = idx;
            end
            idx = next_id(idx);
        end
    end

endmodule

// File: rtl/iob_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port between N packet streams;
// a grant is held until the packet ends or MAX_BURST beats have been written.
module iob_fifo_wr_arbiter
    import iob_fifo_wr_arbiter_pkg::*;
#(
    parameter int N         = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int MAX_BURST = 16,
    parameter int MIN_FREE  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cke_i,
    input  logic [N-1:0]          req_valid_i,
    input  logic [N-1:0]          req_last_i,
    input  logic [N*DATA_W-1:0]   req_data_i,
    output logic [N-1:0]          req_ready_o,
    output logic                  fifo_w_en_o,
    output logic [DATA_W-1:0]     fifo_w_data_o,
    input  logic                  fifo_w_full_i,
    input  logic [ADDR_W:0]       fifo_w_level_i,
    output logic                  grant_valid_o,
    output logic [$clog2(N)-1:0]  grant_id_o
);

    localparam int ID_W  = $clog2(N);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [ADDR_W:0]  DEPTH      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  MIN_FREE_W = (ADDR_W + 1)'(MIN_FREE);
    localparam logic [CNT_W-1:0] CNT_CAP    = CNT_W'(MAX_BURST);

    arb_state_t        state;
    logic [ID_W-1:0]   last_id;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ADDR_W:0]   free_words;
    logic [ID_W-1:0]   winner_id;
    logic              any_req;
    logic              admit;
    logic              accept;
    logic              burst_end;
    logic [DATA_W-1:0] grant_data;

    iob_rr_prio_enc #(
        .N    (N),
        .ID_W (ID_W)
    ) u_rr_prio_enc (
        .req       (req_valid_i),
        .last_id   (last_id),
        .winner_id (winner_id),
        .any       (any_req)
    );

    // The level lags real occupancy, so this is only an admission filter;
    // the full flag still gates every individual beat.
    assign free_words = DEPTH - fifo_w_level_i;
    assign admit      = any_req && (free_words >= MIN_FREE_W);

    assign grant_data = req_data_i[int'(grant_id_o) * DATA_W +: DATA_W];

    always_comb begin
        req_ready_o = '0;
        if (state == BURST) begin
            req_ready_o[grant_id_o] = ~fifo_w_full_i;
        end
    end

    assign accept        = (state == BURST) && req_valid_i[grant_id_o] && !fifo_w_full_i && cke_i;
    assign fifo_w_en_o   = accept;
    assign fifo_w_data_o = accept ? grant_data : '0;

    // A burst hitting the cap without last is split; the remainder waits for the next win.
    assign burst_end = req_last_i[grant_id_o] || ((beat_cnt + 1'b1) == CNT_CAP);

    // NOTE: state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            last_id       <= ID_W'(N - 1);
            grant_id_o    <= '0;
            grant_valid_o <= 1'b0;
            beat_cnt      <= '0;
        end else if (cke_i) begin
            case (state)
                IDLE: begin
                    if (admit) begin
                        state         <= BURST;
                        grant_id_o    <= winner_id;
                        grant_valid_o <= 1'b1;
                        beat_cnt      <= '0;
                    end
                end
                BURST: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (burst_end) begin
                            state         <= IDLE;
                            grant_valid_o <= 1'b0;
                            last_id       <= grant_id_o;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_fifo_wr_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared cycle by
// cycle against a transaction-level reference model of the arbitration rules.
module tb_iob_fifo_wr_arbiter;

    localparam int N         = 4;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 8;
    localparam int MAX_BURST = 16;
    localparam int MIN_FREE  = 4;
    localparam int QD        = 256;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cke;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_last;
    logic [N*DATA_W-1:0] req_data;
    logic [N-1:0]        req_ready;
    logic                w_en;
    logic [DATA_W-1:0]   w_data;
    logic                full;
    logic [ADDR_W:0]     level;
    logic                grant_valid;
    logic [1:0]          grant_id;

    always #5 clk = ~clk;

    iob_fifo_wr_arbiter #(
        .N         (N),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MAX_BURST (MAX_BURST),
        .MIN_FREE  (MIN_FREE)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .cke_i          (cke),
        .req_valid_i    (req_valid),
        .req_last_i     (req_last),
        .req_data_i     (req_data),
        .req_ready_o    (req_ready),
        .fifo_w_en_o    (w_en),
        .fifo_w_data_o  (w_data),
        .fifo_w_full_i  (full),
        .fifo_w_level_i (level),
        .grant_valid_o  (grant_valid),
        .grant_id_o     (grant_id)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-requester packet streams: bit 32 is last, bits 31:0 the beat data.
    logic [32:0] beats [N][QD];
    int          head [N];
    int          tail [N];
    int          seq  [N];
    logic [N-1:0] hold;

    // Reference model state: who holds the grant and for how many beats.
    bit m_busy;
    int m_gid;
    int m_last;
    int m_cnt;
    int cyc;

    logic [31:0] wlog [$];
    int          wcyc [$];
    logic [31:0] elog [$];

    function automatic logic [31:0] beat_val(input int k, input int s);
        return {8'(k), 24'(s)};
    endfunction

    task automatic push_beat(input int k, input logic [31:0] d, input logic last);
        beats[k][tail[k]] = {last, d};
        tail[k]++;
    endtask

    task automatic push_packet(input int k, input int len);
        for (int b = 0; b < len; b++) begin
            push_beat(k, beat_val(k, seq[k]), b == len - 1);
            seq[k]++;
        end
    endtask

    task automatic step();
        logic [N-1:0]  exp_ready;
        logic          exp_acc;
        logic [31:0]   exp_data;
        int            free;
        for (int k = 0; k < N; k++) begin
            logic v;
            v = (head[k] != tail[k]) && !hold[k];
            req_valid[k] = v;
            req_last[k]  = v ? beats[k][head[k]][32] : 1'($urandom % 2);
            req_data[k*DATA_W +: DATA_W] = v ? beats[k][head[k]][31:0] : $urandom;
        end
        @(negedge clk);
        exp_ready = (m_busy && !full) ? (4'b0001 << m_gid) : 4'b0000;
        exp_acc   = m_busy && req_valid[m_gid] && !full && cke;
        exp_data  = exp_acc ? req_data[m_gid*DATA_W +: DATA_W] : 32'h0;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("w_en", 32'(w_en), 32'(exp_acc));
        check("w_data", w_data, exp_data);
        check("grant_valid", 32'(grant_valid), 32'(m_busy));
        check("grant_id", 32'(grant_id), m_gid);
        if (w_en) begin
            wlog.push_back(w_data);
            wcyc.push_back(cyc);
        end
        @(posedge clk);
        if (exp_acc) head[m_gid]++;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = N - 1;
            m_gid  = 0;
            m_cnt  = 0;
        end else if (cke) begin
            if (!m_busy) begin
                free = (1 << ADDR_W) - int'(level);
                if (req_valid != '0 && free >= MIN_FREE) begin
                    for (int s = 1; s <= N; s++) begin
                        if (req_valid[(m_last + s) % N]) begin
                            m_gid = (m_last + s) % N;
                            break;
                        end
                    end
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end
            end else if (exp_acc) begin
                m_cnt++;
                if (req_last[m_gid] || m_cnt == MAX_BURST) begin
                    m_busy = 1'b0;
                    m_last = m_gid;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cke   = 1'b1;
        full  = 1'b0;
        level = '0;
        hold  = '0;
        for (int k = 0; k < N; k++) begin
            head[k] = 0;
            tail[k] = 0;
            seq[k]  = 0;
        end
        run(2);
        rst_n = 1'b1;
        wlog.delete();
        wcyc.delete();
        elog.delete();
    endtask

    task automatic compare_log(input string tag);
        int n;
        check({tag, "_len"}, wlog.size(), elog.size());
        n = (wlog.size() < elog.size()) ? wlog.size() : elog.size();
        for (int i = 0; i < n; i++) check({tag, "_beat"}, wlog[i], elog[i]);
    endtask

    initial begin
        int c0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        m_busy    = 1'b0;
        m_gid     = 0;
        m_last    = N - 1;
        m_cnt     = 0;
        cyc       = 0;

        // Reset state and a single 3-beat packet into an empty FIFO.
        do_reset();
        push_beat(0, 32'hA, 1'b0);
        push_beat(0, 32'hB, 1'b0);
        push_beat(0, 32'hC, 1'b1);
        c0 = cyc;
        run(6);
        elog = '{32'hA, 32'hB, 32'hC};
        compare_log("single");
        if (wcyc.size() == 3) begin
            check("single_latency", wcyc[0], c0 + 1);
            check("single_gap1", wcyc[1] - wcyc[0], 1);
            check("single_gap2", wcyc[2] - wcyc[1], 1);
        end
        check("single_gid", 32'(grant_id), 0);

        // All requesters with 1-beat packets: strict rotation, one write per 2 cycles.
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < N; k++) push_packet(k, 1);
        run(30);
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < N; k++) elog.push_back(beat_val(k, r));
        compare_log("rotate");
        for (int i = 1; i < wcyc.size(); i++) check("rotate_gap", wcyc[i] - wcyc[i-1], 2);

        // 40-beat packet split at the burst cap, interleaved with req2 packets.
        do_reset();
        push_packet(1, 40);
        push_packet(2, 3);
        push_packet(2, 3);
        run(70);
        for (int s = 0;  s < 16; s++) elog.push_back(beat_val(1, s));
        for (int s = 0;  s < 3;  s++) elog.push_back(beat_val(2, s));
        for (int s = 16; s < 32; s++) elog.push_back(beat_val(1, s));
        for (int s = 3;  s < 6;  s++) elog.push_back(beat_val(2, s));
        for (int s = 32; s < 40; s++) elog.push_back(beat_val(1, s));
        compare_log("split");

        // Full stall mid-burst: no writes while full, no lost or repeated beat.
        do_reset();
        push_packet(0, 10);
        run(3);
        full = 1'b1;
        run(5);
        check("stall_writes", wlog.size(), 2);
        full = 1'b0;
        run(15);
        for (int s = 0; s < 10; s++) elog.push_back(beat_val(0, s));
        compare_log("stall");

        // Admission filter: free=3 blocks the grant, free=4 admits it next cycle.
        do_reset();
        level = 9'd253;
        push_packet(3, 1);
        run(4);
        check("adm_blocked_writes", wlog.size(), 0);
        check("adm_blocked_grant", 32'(grant_valid), 0);
        level = 9'd252;
        step();
        check("adm_grant_valid", 32'(grant_valid), 1);
        check("adm_grant_id", 32'(grant_id), 3);
        run(3);
        elog.push_back(beat_val(3, 0));
        compare_log("adm");

        // Reset during beat 5 of a burst: back to IDLE, requester 0 first afterwards.
        do_reset();
        push_packet(2, 10);
        run(5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_grant_valid", 32'(grant_valid), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        push_packet(0, 1);
        run(20);
        for (int s = 0; s < 5; s++)  elog.push_back(beat_val(2, s));
        elog.push_back(beat_val(0, 0));
        for (int s = 5; s < 10; s++) elog.push_back(beat_val(2, s));
        compare_log("rst");

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) begin
                if (head[k] == tail[k] && ($urandom % 4) == 0) begin
                    head[k] = 0;
                    tail[k] = 0;
                    push_packet(k, 1 + int'($urandom % 24));
                end
                hold[k] = ($urandom % 4) == 0;
            end
            full  = ($urandom % 6) == 0;
            level = 9'(248 + ($urandom % 9));
            cke   = ($urandom % 10) != 0;
            rst_n = ($urandom % 200) != 0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
